// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 single-precision multiplier.
// Inputs are flushed to zero, rounding is nearest-even, and outputs are never denormal.
module fp_mul_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        D,
   output logic [31:0] C,
   output logic        V
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // valid_reg[0..2] are the S1, S2 and S3 stage valid bits
   logic [2:0] valid_reg;

   // ---------------- S1: unpack / classify / sign / exponent sum ----------------
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   logic        s1_sign_next, s1_nan_next, s1_inf_next, s1_zero_next;
   logic [9:0]  s1_exp_next;

   logic        s1_sign_reg, s1_nan_reg, s1_inf_reg, s1_zero_reg;
   logic [9:0]  s1_exp_reg;
   logic [22:0] s1_fa_reg, s1_fb_reg;

   always_comb begin
      ea     = A[30:23];
      eb     = B[30:23];
      fa     = A[22:0];
      fb     = B[22:0];
      a_zero = (ea == 8'h00);
      b_zero = (eb == 8'h00);
      a_inf  = (ea == 8'hFF) && (fa == 23'd0);
      b_inf  = (eb == 8'hFF) && (fb == 23'd0);
      a_nan  = (ea == 8'hFF) && (fa != 23'd0);
      b_nan  = (eb == 8'hFF) && (fb != 23'd0);

      s1_sign_next = A[31] ^ B[31];
      // infinity times a flushed zero is invalid, same as a NaN operand
      s1_nan_next  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
      s1_inf_next  = (a_inf || b_inf) && !s1_nan_next;
      s1_zero_next = (a_zero || b_zero) && !s1_nan_next;
      // two's complement sum, range -127..383 fits comfortably in 10 bits
      s1_exp_next  = {2'b00, ea} + {2'b00, eb} - 10'd127;
   end

   always_ff @(posedge clk) begin
      s1_sign_reg <= s1_sign_next;
      s1_nan_reg  <= s1_nan_next;
      s1_inf_reg  <= s1_inf_next;
      s1_zero_reg <= s1_zero_next;
      s1_exp_reg  <= s1_exp_next;
      s1_fa_reg   <= fa;
      s1_fb_reg   <= fb;
   end

   // ---------------- S2: 24x24 significand product ----------------
   logic [47:0] s2_prod_next;
   logic [47:0] s2_prod_reg;
   logic        s2_sign_reg, s2_nan_reg, s2_inf_reg, s2_zero_reg;
   logic [9:0]  s2_exp_reg;

   always_comb begin
      s2_prod_next = 48'({1'b1, s1_fa_reg}) * 48'({1'b1, s1_fb_reg});
   end

   always_ff @(posedge clk) begin
      s2_prod_reg <= s2_prod_next;
      s2_sign_reg <= s1_sign_reg;
      s2_nan_reg  <= s1_nan_reg;
      s2_inf_reg  <= s1_inf_reg;
      s2_zero_reg <= s1_zero_reg;
      s2_exp_reg  <= s1_exp_reg;
   end

   // ---------------- S3: normalize / round / pack ----------------
   logic        norm_shift;
   logic [22:0] frac_pre;
   logic        guard_bit, sticky_bit, round_up, round_carry;
   logic [22:0] frac_rnd;
   logic [10:0] exp_final;
   logic        exp_ovf, exp_unf;
   logic [31:0] s3_result_next;
   logic [31:0] s3_result_reg;

   always_comb begin
      norm_shift = s2_prod_reg[47];
      if (norm_shift) begin
         frac_pre   = s2_prod_reg[46:24];
         guard_bit  = s2_prod_reg[23];
         sticky_bit = |s2_prod_reg[22:0];
      end else begin
         frac_pre   = s2_prod_reg[45:23];
         guard_bit  = s2_prod_reg[22];
         sticky_bit = |s2_prod_reg[21:0];
      end

      round_up = guard_bit && (sticky_bit || frac_pre[0]);
      // carry out of the fraction means the significand rounded up to 2.0;
      // the wrapped fraction is already zero, so only the exponent moves
      {round_carry, frac_rnd} = {1'b0, frac_pre} + {23'd0, round_up};

      exp_final = {s2_exp_reg[9], s2_exp_reg}
                + {10'd0, norm_shift}
                + {10'd0, round_carry};
      exp_ovf   = !exp_final[10] && (exp_final[9:0] >= 10'd255);
      exp_unf   = exp_final[10] || (exp_final == 11'd0);

      // special operands take priority over arithmetic over/underflow
      if (s2_nan_reg) begin
         s3_result_next = QNAN;
      end else if (s2_inf_reg) begin
         s3_result_next = {s2_sign_reg, 8'hFF, 23'd0};
      end else if (s2_zero_reg) begin
         s3_result_next = {s2_sign_reg, 31'd0};
      end else if (exp_ovf) begin
         s3_result_next = {s2_sign_reg, 8'hFF, 23'd0};
      end else if (exp_unf) begin
         s3_result_next = {s2_sign_reg, 31'd0};
      end else begin
         s3_result_next = {s2_sign_reg, exp_final[7:0], frac_rnd};
      end
   end

   always_ff @(posedge clk) begin
      s3_result_reg <= s3_result_next;
   end

   // ---------------- valid chain and output register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= 3'b000;
         V         <= 1'b0;
         C         <= 32'h0000_0000;
      end else begin
         valid_reg <= {valid_reg[1:0], D};
         V         <= valid_reg[2];
         if (valid_reg[2]) begin
            C <= s3_result_reg;
         end
      end
   end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: A  input  32  IEEE-754 single multiplicand.
REQ-004 SHALL have port: B  input  32  IEEE-754 single multiplier.
REQ-005 SHALL have port: D  input  1  input valid; A/B sampled on a rising edge where D=1 and rst=0.
REQ-006 SHALL have port: C  output  32  IEEE-754 single product A*B.
REQ-007 SHALL have port: V  output  1  output valid; C holds a new product in the cycle V=1.
REQ-008 SHALL have parameter: none; widths fixed at fp32.

Function
REQ-009 SHALL be a 3-stage pipeline: S1 unpack/classify/sign/exponent sum, S2 24x24 mantissa product, S3 normalize/round/pack.
REQ-010 SHALL produce C and V exactly 3 rising edges after the edge that sampled D=1 (latency 3, throughput 1/cycle).
REQ-011 SHALL carry a per-stage valid bit; a bubble (D=0) propagates as V=0 in the matching output cycle.
REQ-012 SHALL hold C at its last value while V=0; C updates only on edges where the S3 valid bit is 1.
REQ-013 SHALL have no backpressure; every accepted operand pair produces exactly one V=1 cycle.
REQ-014 SHALL compute sign = A[31] XOR B[31] for all results, including zero and infinity.
REQ-015 SHALL treat exponent field 0 (zero or denormal) as signed zero (flush-to-zero on input).
REQ-016 SHALL form unbiased exponent sum as EA + EB - 127 in at least 10-bit signed arithmetic.
REQ-017 SHALL multiply 24-bit significands (hidden 1 restored) into a 48-bit product; if product bit 47 = 1, shift right 1 and increment exponent.
REQ-018 SHALL round to nearest, ties to even, using guard bit and sticky OR of all lower product bits.
REQ-019 SHALL renormalize when rounding carries out of the 24-bit significand (increment exponent, significand = 1.0).
REQ-020 SHALL output signed infinity (exp 0xFF, frac 0) when the final biased exponent >= 255.
REQ-021 SHALL output signed zero when the final biased exponent <= 0 (no denormal outputs).
REQ-022 SHALL output 0x7FC00000 when either input is NaN, or one input is infinity and the other zero/denormal.
REQ-023 SHALL output signed infinity when one input is infinity and the other is finite nonzero, or both are infinity.
REQ-024 SHALL give special-case results (REQ-022/023/015) priority over arithmetic overflow/underflow.

Reset
REQ-025 SHALL, on any rising edge with rst=1, clear C to 32'h00000000, V to 0, and all stage valid bits to 0.
REQ-026 SHALL discard all in-flight operations on reset; no V=1 for operands sampled before or during the reset edge.
REQ-027 SHALL accept a new operand on the first edge with rst=0 and D=1, output V=1 three edges later.
REQ-028 SHALL ignore D while rst=1.

Verification
REQ-029 SHALL pass: D=1, A=0x40000000, B=0x3F800000 -> 3 edges later V=1, C=0x40000000.
REQ-030 SHALL pass: back-to-back D=1 for three cycles with (0x41800000,0x40000000), (0x3FC00000,0x3E000000), (0x3F800001,0x3F800001) -> consecutive V=1 cycles, C=0x42000000, 0x3E400000, 0x3F800002 (RNE).
REQ-031 SHALL pass: (0x7F000000,0x40000000) -> 0x7F800000; (0x80800000,0x00800000) -> 0x80000000 (underflow flush, sign kept).
REQ-032 SHALL pass: (0x00000000,0x7F800000) -> 0x7FC00000; (0xFF800000,0x40000000) -> 0xFF800000; (0x7FC00000,0x3F800000) -> 0x7FC00000.
REQ-033 SHALL pass: D pattern 1,0,1 -> V pattern 1,0,1 after 3 edges, C held through the V=0 cycle.
REQ-034 SHALL pass: two operands accepted, rst=1 asserted one edge later for one cycle -> C=0x00000000, V=0, no V=1 ever produced for those operands.
